// File: rtl/video_timing_gen_if.sv
// Raster timing bundle between the timing generator (master) and its consumers (slave).
// IRQ_LINE/LINE_IRQ exist only when VTG_LINE_IRQ_EN is defined.
interface video_timing_gen_if #(
    parameter int HW = 9,
    parameter int VW = 9
);
    logic          PIX_CE;
    logic          CLK_6M;
    logic [HW-1:0] HCOUNT;
    logic [VW-1:0] VCOUNT;
    logic          CLK_1H;
    logic          CLK_2H;
    logic          CLK_4H;
    logic          HSYNC;
    logic          VSYNC;
    logic          COMPSYNC;
    logic          HBLANK;
    logic          VBLANK;
    logic          BLANKING;
    logic          HRESET;
    logic          VRESET;
`ifdef VTG_LINE_IRQ_EN
    logic [VW-1:0] IRQ_LINE;
    logic          LINE_IRQ;

    modport master (
        output PIX_CE, CLK_6M, HCOUNT, VCOUNT, CLK_1H, CLK_2H, CLK_4H,
        output HSYNC, VSYNC, COMPSYNC, HBLANK, VBLANK, BLANKING, HRESET, VRESET,
        input  IRQ_LINE,
        output LINE_IRQ
    );
    modport slave (
        input  PIX_CE, CLK_6M, HCOUNT, VCOUNT, CLK_1H, CLK_2H, CLK_4H,
        input  HSYNC, VSYNC, COMPSYNC, HBLANK, VBLANK, BLANKING, HRESET, VRESET,
        output IRQ_LINE,
        input  LINE_IRQ
    );
`else
    modport master (
        output PIX_CE, CLK_6M, HCOUNT, VCOUNT, CLK_1H, CLK_2H, CLK_4H,
        output HSYNC, VSYNC, COMPSYNC, HBLANK, VBLANK, BLANKING, HRESET, VRESET
    );
    modport slave (
        input  PIX_CE, CLK_6M, HCOUNT, VCOUNT, CLK_1H, CLK_2H, CLK_4H,
        input  HSYNC, VSYNC, COMPSYNC, HBLANK, VBLANK, BLANKING, HRESET, VRESET
    );
`endif
endinterface

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel divider, H/V counters and registered decodes.
// Optional per-line interrupt comparator enabled by defining VTG_LINE_IRQ_EN.
module video_timing_gen #(
    parameter int CLK_DIV      = 8,
    parameter int H_TOTAL      = 384,
    parameter int H_ACTIVE     = 288,
    parameter int H_SYNC_START = 304,
    parameter int H_SYNC_WIDTH = 32,
    parameter int V_TOTAL      = 264,
    parameter int V_ACTIVE     = 224,
    parameter int V_SYNC_START = 240,
    parameter int V_SYNC_WIDTH = 8,
    parameter int SYNC_POL     = 0,
    parameter int HW           = $clog2(H_TOTAL),
    parameter int VW           = $clog2(V_TOTAL)
) (
    input  logic               CLK_48M,
    input  logic               RST,
    video_timing_gen_if.master vt
);
    localparam int             DW       = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0]  H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0]  V_LAST   = VW'(V_TOTAL - 1);
    localparam logic           POL      = (SYNC_POL != 0);

    if (H_SYNC_START + H_SYNC_WIDTH > H_TOTAL) begin : g_chk_hsync
        $fatal(1, "video_timing_gen: HSYNC window exceeds H_TOTAL");
    end
    if (V_SYNC_START + V_SYNC_WIDTH > V_TOTAL) begin : g_chk_vsync
        $fatal(1, "video_timing_gen: VSYNC window exceeds V_TOTAL");
    end
    if (H_ACTIVE >= H_TOTAL || V_ACTIVE >= V_TOTAL) begin : g_chk_active
        $fatal(1, "video_timing_gen: active area must be smaller than total");
    end
    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_chk_div
        $fatal(1, "video_timing_gen: CLK_DIV must be even and >= 2");
    end

    logic [DW-1:0] div, div_nx;
    logic [HW-1:0] hcount, hcount_nx;
    logic [VW-1:0] vcount, vcount_nx;
    logic          tick, hwrap;
    logic          hs_nx, vs_nx;
    logic          pix_ce, clk_pix;
    logic          hsync, vsync, compsync;
    logic          hblank, vblank, hreset, vreset;

    // Decodes look at the next-state counts so they land on the same edge as the counters.
    always_comb begin
        tick      = (div == DIV_LAST);
        hwrap     = tick && (hcount == H_LAST);
        div_nx    = tick ? '0 : div + 1'b1;
        hcount_nx = hcount;
        vcount_nx = vcount;
        if (tick) begin
            hcount_nx = hwrap ? '0 : hcount + 1'b1;
            if (hwrap) begin
                vcount_nx = (vcount == V_LAST) ? '0 : vcount + 1'b1;
            end
        end
        hs_nx = (int'(hcount_nx) >= H_SYNC_START) &&
                (int'(hcount_nx) <  H_SYNC_START + H_SYNC_WIDTH);
        vs_nx = (int'(vcount_nx) >= V_SYNC_START) &&
                (int'(vcount_nx) <  V_SYNC_START + V_SYNC_WIDTH);
    end

    always_ff @(posedge CLK_48M) begin
        if (RST) begin
            div      <= '0;
            hcount   <= '0;
            vcount   <= '0;
            pix_ce   <= 1'b0;
            clk_pix  <= 1'b1;
            hsync    <= ~POL;
            vsync    <= ~POL;
            compsync <= ~POL;
            hblank   <= 1'b0;
            vblank   <= 1'b0;
            hreset   <= 1'b0;
            vreset   <= 1'b0;
        end else begin
            div      <= div_nx;
            hcount   <= hcount_nx;
            vcount   <= vcount_nx;
            pix_ce   <= (div_nx == DIV_LAST);
            clk_pix  <= (div_nx < DIV_HALF);
            hsync    <= hs_nx ^ ~POL;
            vsync    <= vs_nx ^ ~POL;
            compsync <= (hs_nx ^ vs_nx) ^ ~POL;
            hblank   <= (int'(hcount_nx) >= H_ACTIVE);
            vblank   <= (int'(vcount_nx) >= V_ACTIVE);
            hreset   <= (hcount_nx == H_LAST);
            vreset   <= (hcount_nx == H_LAST) && (vcount_nx == V_LAST);
        end
    end

`ifdef VTG_LINE_IRQ_EN
    logic line_irq;

    // Out-of-range compare lines can never match vcount_nx, so they stay silent.
    always_ff @(posedge CLK_48M) begin
        if (RST) begin
            line_irq <= 1'b0;
        end else begin
            line_irq <= hwrap && (vcount_nx == vt.IRQ_LINE);
        end
    end

    assign vt.LINE_IRQ = line_irq;
`endif

    assign vt.PIX_CE   = pix_ce;
    assign vt.CLK_6M   = clk_pix;
    assign vt.HCOUNT   = hcount;
    assign vt.VCOUNT   = vcount;
    assign vt.CLK_1H   = hcount[0];
    assign vt.CLK_2H   = hcount[1];
    assign vt.CLK_4H   = hcount[2];
    assign vt.HSYNC    = hsync;
    assign vt.VSYNC    = vsync;
    assign vt.COMPSYNC = compsync;
    assign vt.HBLANK   = hblank;
    assign vt.VBLANK   = vblank;
    assign vt.BLANKING = hblank | vblank;
    assign vt.HRESET   = hreset;
    assign vt.VRESET   = vreset;
endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: arithmetic raster model vs two DUT geometries.
module tb_video_timing_gen;
    typedef struct packed {
        int dv, ht, ha, hss, hsw, vt, va, vss, vsw, pol;
    } cfg_t;

    typedef struct packed {
        logic        pix_ce, clk6, h1, h2, h4, hs, vs, cs, hb, vb, bl, hr, vr, irq;
        logic [15:0] hc, vc;
    } obs_t;

    localparam cfg_t CFG_D = '{8, 384, 288, 304, 32, 264, 224, 240, 8, 0};
    localparam cfg_t CFG_S = '{2, 64, 48, 52, 4, 20, 16, 17, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d = 1'b0;
    logic rst_s = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   d_done = 0;
    bit   s_done = 0;
    int   epoch_s = 0;
    obs_t q_d[$];
    obs_t q_s[$];

    video_timing_gen_if #(.HW(9), .VW(9)) vd ();
    video_timing_gen_if #(.HW(6), .VW(5)) vs_if ();

    video_timing_gen dut_d (.CLK_48M(clk), .RST(rst_d), .vt(vd));

    video_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(64), .H_ACTIVE(48), .H_SYNC_START(52), .H_SYNC_WIDTH(4),
        .V_TOTAL(20), .V_ACTIVE(16), .V_SYNC_START(17), .V_SYNC_WIDTH(2), .SYNC_POL(1)
    ) dut_s (.CLK_48M(clk), .RST(rst_s), .vt(vs_if));

    // Raster position follows directly from master cycles elapsed since the reset edge.
    function automatic obs_t model(cfg_t cf, int c, int irq_line);
        obs_t o;
        int d, pix, h, v;
        bit hs, vs;
        o   = '0;
        d   = c % cf.dv;
        pix = c / cf.dv;
        h   = pix % cf.ht;
        v   = (pix / cf.ht) % cf.vt;
        hs  = (h >= cf.hss) && (h < cf.hss + cf.hsw);
        vs  = (v >= cf.vss) && (v < cf.vss + cf.vsw);
        o.pix_ce = (d == cf.dv - 1);
        o.clk6   = (d < cf.dv / 2);
        o.hc     = 16'(h);
        o.vc     = 16'(v);
        o.h1     = h[0];
        o.h2     = h[1];
        o.h4     = h[2];
        o.hs     = (cf.pol != 0) ? hs : !hs;
        o.vs     = (cf.pol != 0) ? vs : !vs;
        o.cs     = (cf.pol != 0) ? (hs ^ vs) : !(hs ^ vs);
        o.hb     = (h >= cf.ha);
        o.vb     = (v >= cf.va);
        o.bl     = (h >= cf.ha) || (v >= cf.va);
        o.hr     = (h == cf.ht - 1);
        o.vr     = (h == cf.ht - 1) && (v == cf.vt - 1);
        o.irq    = (c > 0) && (d == 0) && (h == 0) && (v == irq_line);
        return o;
    endfunction

    initial begin : model_d
        int c;
        int il;
        bit live;
        live = 0;
        c = 0;
        forever begin
            @(posedge clk);
`ifdef VTG_LINE_IRQ_EN
            il = int'(vd.IRQ_LINE);
`else
            il = -1;
`endif
            if (rst_d) begin
                c = 0;
                live = 1;
            end else if (live) begin
                c++;
            end
            if (live) q_d.push_back(model(CFG_D, c, il));
        end
    end

    initial begin : model_s
        int c;
        int il;
        bit live;
        live = 0;
        c = 0;
        forever begin
            @(posedge clk);
`ifdef VTG_LINE_IRQ_EN
            il = int'(vs_if.IRQ_LINE);
`else
            il = -1;
`endif
            if (rst_s) begin
                c = 0;
                live = 1;
                epoch_s++;
            end else if (live) begin
                c++;
            end
            if (live) q_s.push_back(model(CFG_S, c, il));
        end
    end

    initial begin : mon_d
        obs_t a, e;
        forever begin
            @(negedge clk);
            if (q_d.size() != 0) begin
                e = q_d.pop_front();
                a = '0;
                a.pix_ce = vd.PIX_CE;   a.clk6 = vd.CLK_6M;
                a.hc = 16'(vd.HCOUNT);  a.vc = 16'(vd.VCOUNT);
                a.h1 = vd.CLK_1H;       a.h2 = vd.CLK_2H;     a.h4 = vd.CLK_4H;
                a.hs = vd.HSYNC;        a.vs = vd.VSYNC;      a.cs = vd.COMPSYNC;
                a.hb = vd.HBLANK;       a.vb = vd.VBLANK;     a.bl = vd.BLANKING;
                a.hr = vd.HRESET;       a.vr = vd.VRESET;
`ifdef VTG_LINE_IRQ_EN
                a.irq = vd.LINE_IRQ;
`endif
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL dut_default t=%0t got h=%0d v=%0d bits=%h expected h=%0d v=%0d bits=%h",
                             $time, a.hc, a.vc, a, e.hc, e.vc, e);
                end
            end
        end
    end

    initial begin : mon_s
        obs_t a, e;
        forever begin
            @(negedge clk);
            if (q_s.size() != 0) begin
                e = q_s.pop_front();
                a = '0;
                a.pix_ce = vs_if.PIX_CE;   a.clk6 = vs_if.CLK_6M;
                a.hc = 16'(vs_if.HCOUNT);  a.vc = 16'(vs_if.VCOUNT);
                a.h1 = vs_if.CLK_1H;       a.h2 = vs_if.CLK_2H;    a.h4 = vs_if.CLK_4H;
                a.hs = vs_if.HSYNC;        a.vs = vs_if.VSYNC;     a.cs = vs_if.COMPSYNC;
                a.hb = vs_if.HBLANK;       a.vb = vs_if.VBLANK;    a.bl = vs_if.BLANKING;
                a.hr = vs_if.HRESET;       a.vr = vs_if.VRESET;
`ifdef VTG_LINE_IRQ_EN
                a.irq = vs_if.LINE_IRQ;
`endif
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL dut_small t=%0t got h=%0d v=%0d bits=%h expected h=%0d v=%0d bits=%h",
                             $time, a.hc, a.vc, a, e.hc, e.vc, e);
                end
            end
        end
    end

    // Frame period on the small geometry: 2 * 64 * 20 master cycles between VRESET rises.
    initial begin : frame_mon
        int  cyc, last, ep;
        logic prev_vr;
        cyc = 0;
        last = -1;
        ep = 0;
        prev_vr = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (epoch_s != ep) begin
                ep = epoch_s;
                last = -1;
            end
            if (vs_if.VRESET && !prev_vr) begin
                if (last >= 0) begin
                    checks++;
                    if (cyc - last != 2560) begin
                        errors++;
                        $display("FAIL frame_period got %0d expected 2560", cyc - last);
                    end
                end
                last = cyc;
            end
            prev_vr = vs_if.VRESET;
        end
    end

    initial begin : stim_d
`ifdef VTG_LINE_IRQ_EN
        vd.IRQ_LINE = 9'd1;
`endif
        rst_d = 1'b1;
        repeat (2) @(negedge clk);
        rst_d = 1'b0;
        // Land the reset pulse inside HSYNC, around HCOUNT 310 on line 2.
        repeat (2 * 3072 + 310 * 8 + 3) @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        repeat (3500 + $urandom_range(0, 7)) @(negedge clk);
        d_done = 1;
    end

    initial begin : stim_s
        int r;
        rst_s = 1'b1;
        repeat (3) @(negedge clk);
        rst_s = 1'b0;
        for (int f = 0; f < 6; f++) begin
`ifdef VTG_LINE_IRQ_EN
            r = int'($urandom_range(0, 2));
            if (f == 0)      vs_if.IRQ_LINE = 5'd16;
            else if (f == 1) vs_if.IRQ_LINE = 5'd25;
            else if (r == 0) vs_if.IRQ_LINE = 5'($urandom_range(20, 31));
            else             vs_if.IRQ_LINE = 5'($urandom_range(0, 19));
`else
            r = 0;
`endif
            repeat (2560 + r) @(negedge clk);
            if (f == 2) begin
                repeat ($urandom_range(100, 2000)) @(negedge clk);
                rst_s = 1'b1;
                @(negedge clk);
                rst_s = 1'b0;
            end
        end
        s_done = 1;
    end

    initial begin : finish_blk
        int budget;
        budget = 0;
        while (!(d_done && s_done) && budget < 60000) begin
            @(negedge clk);
            budget++;
        end
        if (!(d_done && s_done)) begin
            errors++;
            $display("FAIL stimulus_timeout got %0d cycles expected completion", budget);
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised raster timing generator, successor to the fixed System86 timing subsystem.
- Divides the master clock to a pixel-rate enable and runs horizontal/vertical counters.
- Decodes sync, blanking, reset strobes and 1H/2H/4H phase clocks for the CPU, tile, sprite and CLUT subsystems.
- Geometry and sync polarity are parameters, so one block serves System86 (288x224) and future boards.

Parameters:
- CLK_DIV, 8, master clocks per pixel (48 MHz / 8 = 6 MHz); even, >= 2
- H_TOTAL, 384, pixels per line
- H_ACTIVE, 288, visible pixels per line
- H_SYNC_START, 304, first hcount with HSYNC asserted
- H_SYNC_WIDTH, 32, HSYNC length in pixels
- V_TOTAL, 264, lines per frame
- V_ACTIVE, 224, visible lines
- V_SYNC_START, 240, first vcount with VSYNC asserted
- V_SYNC_WIDTH, 8, VSYNC length in lines
- SYNC_POL, 0, 0 = syncs active-low, 1 = active-high
- HW, $clog2(H_TOTAL), hcount width
- VW, $clog2(V_TOTAL), vcount width

Ports:
- CLK_48M, input, 1, master clock
- RST, input, 1, synchronous reset, active-high
- PIX_CE, output, 1, one-master-cycle pixel enable
- CLK_6M, output, 1, 50% duty pixel clock
- HCOUNT, output, HW, horizontal pixel counter
- VCOUNT, output, VW, vertical line counter
- CLK_1H, output, 1, HCOUNT[0]
- CLK_2H, output, 1, HCOUNT[1]
- CLK_4H, output, 1, HCOUNT[2]
- HSYNC, output, 1, horizontal sync (polarity per SYNC_POL)
- VSYNC, output, 1, vertical sync (polarity per SYNC_POL)
- COMPSYNC, output, 1, composite sync (polarity per SYNC_POL)
- HBLANK, output, 1, high when HCOUNT >= H_ACTIVE
- VBLANK, output, 1, high when VCOUNT >= V_ACTIVE
- BLANKING, output, 1, HBLANK | VBLANK
- HRESET, output, 1, high during last pixel of each line
- VRESET, output, 1, high during last pixel of each frame

Behaviour:
- Single clock domain, CLK_48M. All state and every output are registered; no combinational path from counters to outputs.
- Divider: div counts 0..CLK_DIV-1 and wraps. PIX_CE=1 in the cycle where div==CLK_DIV-1. CLK_6M=1 while div < CLK_DIV/2.
- Horizontal: on PIX_CE, HCOUNT increments. At H_TOTAL-1 it wraps to 0.
- Vertical: VCOUNT increments on the PIX_CE where HCOUNT wraps. At V_TOTAL-1 it wraps to 0.
- Decode alignment: all decoded outputs are computed from next-state counts, so they change on the same edge as HCOUNT/VCOUNT (zero latency relative to the counters).
- HSYNC asserted for H_SYNC_START <= HCOUNT < H_SYNC_START+H_SYNC_WIDTH.
- VSYNC asserted for V_SYNC_START <= VCOUNT < V_SYNC_START+V_SYNC_WIDTH. It changes only on line boundaries (HCOUNT==0).
- COMPSYNC = HSYNC XOR VSYNC in active-high sense, then SYNC_POL applied.
- HRESET=1 while HCOUNT==H_TOTAL-1.
- VRESET=1 while HCOUNT==H_TOTAL-1 and VCOUNT==V_TOTAL-1.
- Reset (synchronous, takes priority over everything):
  - div, HCOUNT and VCOUNT go to 0; PIX_CE=0; CLK_6M=1.
  - Syncs inactive; HBLANK=VBLANK=BLANKING=0; HRESET=VRESET=0.
- First PIX_CE after RST deasserts: CLK_DIV cycles after the release edge.
- Reset asserted mid-line or mid-frame: counters restart at 0 on that edge; no partial sync pulse continues.
- Parameter checks at elaboration (fatal on failure):
  - H_SYNC_START+H_SYNC_WIDTH <= H_TOTAL
  - V_SYNC_START+V_SYNC_WIDTH <= V_TOTAL
  - H_ACTIVE < H_TOTAL; V_ACTIVE < V_TOTAL
  - CLK_DIV even and >= 2
- Frame period = CLK_DIV*H_TOTAL*V_TOTAL master cycles (811008 at defaults).

Optional Feature:
- Macro: VTG_LINE_IRQ_EN.
- When defined, the block adds two ports:
  - IRQ_LINE, input, VW: compare line.
  - LINE_IRQ, output, 1: registered pulse lasting exactly one master cycle. It fires on the PIX_CE where HCOUNT wraps to 0 and the new VCOUNT equals IRQ_LINE.
- IRQ_LINE is sampled at that same edge. IRQ_LINE >= V_TOTAL never fires. LINE_IRQ resets to 0.
- When not defined, neither port exists and there is no comparator logic.

Test Plan:
- Reset release, defaults -> PIX_CE first high 8 cycles after release, then every 8 cycles; CLK_6M high 4 cycles, low 4 cycles; HCOUNT=1 after the first PIX_CE.
- Run one line -> HSYNC low for HCOUNT 304..335 (32 pixels = 256 cycles); HBLANK high for HCOUNT 288..383; HRESET high for exactly 8 cycles at HCOUNT=383; HCOUNT then wraps to 0 and VCOUNT increments.
- Run one full frame -> VSYNC low for lines 240..247; VBLANK high for lines 224..263; VRESET high for 8 cycles at (383,263); next frame starts at (0,0) exactly 811008 cycles after the first.
- SYNC_POL=1, H_TOTAL=64, H_ACTIVE=48, H_SYNC_START=52, H_SYNC_WIDTH=4, CLK_DIV=2 -> HSYNC high for HCOUNT 52..55; line length 128 cycles.
- Assert RST for 1 cycle at HCOUNT=310, VCOUNT=100 -> next edge: counters 0, HSYNC inactive, BLANKING=0; normal sequence resumes.
- With VTG_LINE_IRQ_EN defined, IRQ_LINE=16 -> exactly one 1-cycle LINE_IRQ per frame, at the HCOUNT wrap into VCOUNT=16. IRQ_LINE=300 -> no LINE_IRQ.
